// File: rtl/sample_hold_pkg.sv
// Shared types and defaults for the sample/hold stage: FSM state encoding,
// default parameter values and the FIFO occupancy-width helper.
package sample_hold_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PUSH = 2'd2
  } state_t;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_HOLD_CYCLES = 4;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sample_hold_fifo.sv
// Small synchronous FIFO for captured samples. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sample_hold_fifo
  import sample_hold_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is read straight from storage, so it only moves on pop or on the
  // first write into an empty FIFO.
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_hold_stage.sv
// Watches a level-style input word, waits a settle interval after each change
// and queues the settled value. SAMPLE_HOLD_DEBOUNCE_EN restarts the settle
// interval whenever the input moves during it.
//
// state | meaning
// IDLE  | waiting for in_data to differ from the last captured value
// WAIT  | settle countdown running
// PUSH  | captured sample written to FIFO (or dropped if full)
module sample_hold_stage
  import sample_hold_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam logic signed [31:0] HOLD_LD = 32'(HOLD_CYCLES);

  state_t                    state, state_n;
  logic signed [31:0]        wait_counter, wc_n, wc_dec;
  logic signed [DATA_W-1:0]  last_sampled, last_n;
  logic signed [DATA_W-1:0]  sample, sample_n;
  logic                      ovf_n;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [DATA_W-1:0]         fifo_rdata;
`ifdef SAMPLE_HOLD_DEBOUNCE_EN
  logic signed [DATA_W-1:0]  prev_in;
`endif

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata;
  assign pop       = out_valid && out_ready;
  assign wc_dec    = wait_counter - 32'sd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_counter <= '0;
      last_sampled <= '0;
      sample       <= '0;
      overflow     <= 1'b0;
`ifdef SAMPLE_HOLD_DEBOUNCE_EN
      prev_in      <= '0;
`endif
    end else begin
      state        <= state_n;
      wait_counter <= wc_n;
      last_sampled <= last_n;
      sample       <= sample_n;
      overflow     <= ovf_n;
`ifdef SAMPLE_HOLD_DEBOUNCE_EN
      prev_in      <= in_data;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    wc_n     = wait_counter;
    last_n   = last_sampled;
    sample_n = sample;
    ovf_n    = overflow;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (in_data != last_sampled) begin
          wc_n    = HOLD_LD;
          state_n = WAIT;
        end
      end
      WAIT: begin
        wc_n = wc_dec;
`ifdef SAMPLE_HOLD_DEBOUNCE_EN
        if (in_data != prev_in) begin
          wc_n = HOLD_LD;
        end else if (wc_dec == 32'sd0) begin
          sample_n = in_data;
          state_n  = PUSH;
        end
`else
        if (wc_dec == 32'sd0) begin
          sample_n = in_data;
          state_n  = PUSH;
        end
`endif
      end
      PUSH: begin
        push = 1'b1;
        // A same-cycle pop frees the slot, so only a full FIFO with no pop drops.
        if (fifo_full && !pop) ovf_n = 1'b1;
        last_n  = sample;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  sample_hold_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (sample),
    .rdata (fifo_rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
